// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB writes pass straight through, MDU results
// wait in a small queue and drain on WB-idle cycles, with hazard and starvation reporting.
module rf_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  WB_RegWrite_i,
    input  logic [ADDR_WIDTH-1:0] WB_WriteAddress_i,
    input  logic [DATA_WIDTH-1:0] WB_WriteData_i,
    input  logic                  MD_Valid_i,
    input  logic [ADDR_WIDTH-1:0] MD_WriteAddress_i,
    input  logic [DATA_WIDTH-1:0] MD_WriteData_i,
    output logic                  MD_Ready_o,
    input  logic [ADDR_WIDTH-1:0] ID_Rs_i,
    input  logic [ADDR_WIDTH-1:0] ID_Rt_i,
    output logic                  MD_HazardA_o,
    output logic                  MD_HazardB_o,
    output logic                  RF_RegWrite_o,
    output logic [ADDR_WIDTH-1:0] RF_WriteAddress_o,
    output logic [DATA_WIDTH-1:0] RF_WriteData_o,
    output logic                  Stall_Req_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(STARVE_LIMIT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_STARVED = 2'd2;

    logic [PTR_W:0]          headQ, headD, tailQ, tailD;
    logic [PTR_W:0]          fillCount;
    logic [PTR_W-1:0]        headIdx, tailIdx;
    logic [ADDR_WIDTH-1:0]   addrQ [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   dataQ [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   liveQ, liveD;
    logic [1:0]              stateQ, stateD;
    logic [CNT_W-1:0]        starveQ, starveD;

    logic notFull, isEmpty, nextEmpty;
    logic headLive, headDead, mdGrant, deq, enq, blocked, kill;
    logic hazA, hazB;

    assign fillCount = tailQ - headQ;
    assign headIdx   = headQ[PTR_W-1:0];
    assign tailIdx   = tailQ[PTR_W-1:0];
    assign notFull   = (fillCount != DEPTH_CNT);
    assign isEmpty   = (headQ == tailQ);

    assign headLive  = !isEmpty && liveQ[headIdx];
    assign headDead  = !isEmpty && !liveQ[headIdx];
    assign mdGrant   = headLive && !WB_RegWrite_i;
    assign blocked   = headLive && WB_RegWrite_i;
    assign deq       = mdGrant || headDead;
    assign enq       = MD_Valid_i && notFull;
    assign kill      = WB_RegWrite_i && (WB_WriteAddress_i != '0);

    assign headD     = headQ + {{PTR_W{1'b0}}, deq};
    assign tailD     = tailQ + {{PTR_W{1'b0}}, enq};
    assign nextEmpty = (headD == tailD);

    // A newer WB write to the same register makes queued results obsolete;
    // the entry enqueued this edge is younger than the WB write and survives.
    always_comb begin
        liveD = liveQ;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (kill && (addrQ[i] == WB_WriteAddress_i)) begin
                liveD[i] = 1'b0;
            end
        end
        if (deq) begin
            liveD[headIdx] = 1'b0;
        end
        if (enq) begin
            liveD[tailIdx] = (MD_WriteAddress_i != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            headQ <= '0;
            tailQ <= '0;
            liveQ <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addrQ[i] <= '0;
                dataQ[i] <= '0;
            end
        end else begin
            headQ <= headD;
            tailQ <= tailD;
            liveQ <= liveD;
            if (enq) begin
                addrQ[tailIdx] <= MD_WriteAddress_i;
                dataQ[tailIdx] <= MD_WriteData_i;
            end
        end
    end

    // Starvation tracking: blocked cycles accumulate only while the head stays put.
    always_comb begin
        stateD  = stateQ;
        starveD = starveQ;
        case (stateQ)
            ST_IDLE: begin
                starveD = '0;
                if (enq) begin
                    stateD = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (deq) begin
                    starveD = '0;
                    if (nextEmpty) begin
                        stateD = ST_IDLE;
                    end
                end else if (blocked) begin
                    starveD = starveQ + 1'b1;
                    if (starveQ >= LIMIT_M1) begin
                        stateD = ST_STARVED;
                    end
                end
            end
            ST_STARVED: begin
                if (deq) begin
                    starveD = '0;
                    stateD  = nextEmpty ? ST_IDLE : ST_PENDING;
                end
            end
            default: begin
                stateD  = ST_IDLE;
                starveD = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ  <= ST_IDLE;
            starveQ <= '0;
        end else begin
            stateQ  <= stateD;
            starveQ <= starveD;
        end
    end

    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            hazA = hazA | (liveQ[i] && (addrQ[i] == ID_Rs_i));
            hazB = hazB | (liveQ[i] && (addrQ[i] == ID_Rt_i));
        end
    end

    assign MD_HazardA_o = hazA && (ID_Rs_i != '0);
    assign MD_HazardB_o = hazB && (ID_Rt_i != '0);
    assign MD_Ready_o   = rst_ni && notFull;
    assign Stall_Req_o  = (stateQ == ST_STARVED);

    // Outputs are gated by reset so nothing reaches the register file while it is held.
    always_comb begin
        RF_RegWrite_o     = 1'b0;
        RF_WriteAddress_o = '0;
        RF_WriteData_o    = '0;
        if (rst_ni) begin
            if (WB_RegWrite_i) begin
                RF_RegWrite_o     = 1'b1;
                RF_WriteAddress_o = WB_WriteAddress_i;
                RF_WriteData_o    = WB_WriteData_i;
            end else if (headLive) begin
                RF_RegWrite_o     = 1'b1;
                RF_WriteAddress_o = addrQ[headIdx];
                RF_WriteData_o    = dataQ[headIdx];
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic, compared each
// cycle against a queue-based model of the arbitration rules.
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        WB_RegWrite_i = 1'b0;
    logic [4:0]  WB_WriteAddress_i = '0;
    logic [31:0] WB_WriteData_i = '0;
    logic        MD_Valid_i = 1'b0;
    logic [4:0]  MD_WriteAddress_i = '0;
    logic [31:0] MD_WriteData_i = '0;
    logic        MD_Ready_o;
    logic [4:0]  ID_Rs_i = '0;
    logic [4:0]  ID_Rt_i = '0;
    logic        MD_HazardA_o, MD_HazardB_o;
    logic        RF_RegWrite_o;
    logic [4:0]  RF_WriteAddress_o;
    logic [31:0] RF_WriteData_o;
    logic        Stall_Req_o;

    rf_write_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .WB_RegWrite_i(WB_RegWrite_i), .WB_WriteAddress_i(WB_WriteAddress_i),
        .WB_WriteData_i(WB_WriteData_i),
        .MD_Valid_i(MD_Valid_i), .MD_WriteAddress_i(MD_WriteAddress_i),
        .MD_WriteData_i(MD_WriteData_i), .MD_Ready_o(MD_Ready_o),
        .ID_Rs_i(ID_Rs_i), .ID_Rt_i(ID_Rt_i),
        .MD_HazardA_o(MD_HazardA_o), .MD_HazardB_o(MD_HazardB_o),
        .RF_RegWrite_o(RF_RegWrite_o), .RF_WriteAddress_o(RF_WriteAddress_o),
        .RF_WriteData_o(RF_WriteData_o), .Stall_Req_o(Stall_Req_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        live;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t modelQ[$];
    int     starveCnt = 0;
    bit     stallExp = 1'b0;
    int     totalChecks = 0;
    int     badChecks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected outputs follow directly from the model queue and the current inputs.
    task automatic compareAll();
        bit          expWe, hazA, hazB;
        logic [4:0]  expAddr;
        logic [31:0] expData;
        expWe = 1'b0; expAddr = '0; expData = '0; hazA = 1'b0; hazB = 1'b0;
        if (WB_RegWrite_i) begin
            expWe = 1'b1; expAddr = WB_WriteAddress_i; expData = WB_WriteData_i;
        end else if (modelQ.size() > 0 && modelQ[0].live) begin
            expWe = 1'b1; expAddr = modelQ[0].addr; expData = modelQ[0].data;
        end
        foreach (modelQ[i]) begin
            if (modelQ[i].live && modelQ[i].addr == ID_Rs_i && ID_Rs_i != 0) hazA = 1'b1;
            if (modelQ[i].live && modelQ[i].addr == ID_Rt_i && ID_Rt_i != 0) hazB = 1'b1;
        end
        checkOutput("rf_we", 32'(RF_RegWrite_o), 32'(expWe));
        if (expWe) begin
            checkOutput("rf_addr", 32'(RF_WriteAddress_o), 32'(expAddr));
            checkOutput("rf_data", RF_WriteData_o, expData);
        end
        checkOutput("ready", 32'(MD_Ready_o), 32'(modelQ.size() < DEPTH));
        checkOutput("hazA", 32'(MD_HazardA_o), 32'(hazA));
        checkOutput("hazB", 32'(MD_HazardB_o), 32'(hazB));
        checkOutput("stall", 32'(Stall_Req_o), 32'(stallExp));
    endtask

    task automatic updateModel();
        bit     enq, headLive, blocked, deq;
        entry_t e;
        enq      = MD_Valid_i && (modelQ.size() < DEPTH);
        headLive = modelQ.size() > 0 && modelQ[0].live;
        blocked  = headLive && WB_RegWrite_i;
        deq      = modelQ.size() > 0 && !blocked;
        if (WB_RegWrite_i && WB_WriteAddress_i != 0) begin
            for (int i = 0; i < modelQ.size(); i++) begin
                if (modelQ[i].addr == WB_WriteAddress_i) begin
                    e = modelQ[i];
                    e.live = 1'b0;
                    modelQ[i] = e;
                end
            end
        end
        if (deq) void'(modelQ.pop_front());
        if (enq) begin
            e.live = (MD_WriteAddress_i != 0);
            e.addr = MD_WriteAddress_i;
            e.data = MD_WriteData_i;
            modelQ.push_back(e);
        end
        if (deq) begin
            starveCnt = 0;
            stallExp  = 1'b0;
        end else if (blocked) begin
            starveCnt++;
            if (starveCnt >= LIMIT) stallExp = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit wbWe, input logic [4:0] wbAddr, input logic [31:0] wbData,
                                 input bit mdV, input logic [4:0] mdAddr, input logic [31:0] mdData,
                                 input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk_i);
        WB_RegWrite_i = wbWe; WB_WriteAddress_i = wbAddr; WB_WriteData_i = wbData;
        MD_Valid_i = mdV; MD_WriteAddress_i = mdAddr; MD_WriteData_i = mdData;
        ID_Rs_i = rs; ID_Rt_i = rt;
        #1 compareAll();
        @(posedge clk_i);
        updateModel();
    endtask

    // Reset lands mid-cycle with WB active and hazard sources aimed at queued entries.
    task automatic doReset();
        @(negedge clk_i);
        WB_RegWrite_i = 1'b1; WB_WriteAddress_i = 5'd6; WB_WriteData_i = 32'h0BAD_0BAD;
        MD_Valid_i = 1'b1; MD_WriteAddress_i = 5'd5;
        ID_Rs_i = (modelQ.size() > 0) ? modelQ[0].addr : 5'd1;
        ID_Rt_i = (modelQ.size() > 1) ? modelQ[1].addr : 5'd2;
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst_we", 32'(RF_RegWrite_o), 32'd0);
        checkOutput("rst_addr", 32'(RF_WriteAddress_o), 32'd0);
        checkOutput("rst_data", RF_WriteData_o, 32'd0);
        checkOutput("rst_ready", 32'(MD_Ready_o), 32'd0);
        checkOutput("rst_hazA", 32'(MD_HazardA_o), 32'd0);
        checkOutput("rst_hazB", 32'(MD_HazardB_o), 32'd0);
        checkOutput("rst_stall", 32'(Stall_Req_o), 32'd0);
        modelQ.delete();
        starveCnt = 0;
        stallExp  = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        WB_RegWrite_i = 1'b0; MD_Valid_i = 1'b0;
        rst_ni = 1'b1;
    endtask

    initial begin
        int pct;
        $display("[TB] start");
        doReset();

        applyStimulus(1, 5'd8, 32'hAAAA5555, 0, 5'd0, 32'h0, 5'd8, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 1, 5'd3, 32'h12, 5'd3, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd3, 5'd3);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd3, 5'd3);

        applyStimulus(1, 5'd10, 32'h1010, 1, 5'd4, 32'h4444, 5'd4, 5'd5);
        applyStimulus(1, 5'd11, 32'h1111, 1, 5'd5, 32'h5555, 5'd4, 5'd5);
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 5'd12, 32'h1200 + i, 1, 5'd7, 32'h7777, 5'd4, 5'd5);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd4, 5'd5);

        applyStimulus(1, 5'd11, 32'hB0B0, 1, 5'd9, 32'h9999, 5'd9, 5'd0);
        applyStimulus(1, 5'd9, 32'h9009, 0, 5'd0, 32'h0, 5'd9, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd9);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd9);

        applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

        applyStimulus(1, 5'd12, 32'hC0C0, 1, 5'd13, 32'h1313, 5'd13, 5'd14);
        applyStimulus(1, 5'd12, 32'hC1C1, 1, 5'd14, 32'h1414, 5'd13, 5'd14);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd13, 5'd14);
        doReset();
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd13, 5'd14);
        applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd13, 5'd14);

        for (int n = 0; n < 1500; n++) begin
            pct = (n < 700) ? 75 : 35;
            if ($urandom_range(0, 249) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom,
                              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
